// File: rtl/mul_vedic_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with signed/unsigned mode per beat
// and a pass-through tag; S1 takes magnitudes, S2 forms the cross partial products, S3 sums and re-signs.
module mul_vedic_pipe #(
  parameter int W     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W;
  localparam logic [W-1:0]  ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};

  // Handshake: a beat moves on valid & ready at the rising edge. A stage loads when it is
  // empty or its content leaves this cycle, so in_ready never looks at in_valid.
  logic en1, en2, en3;
  logic v1_q, v2_q, v3_q;

  assign en3      = !v3_q || out_ready;
  assign en2      = !v2_q || en3;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  // S1: sign of the result and operand magnitudes; -2^(W-1) maps to 2^(W-1) which still fits.
  logic [W-1:0]     abs_a_d, abs_b_d;
  logic             neg_d;
  logic [W-1:0]     ma1_q, mb1_q;
  logic             neg1_q;
  logic [TAG_W-1:0] tag1_q;

  always_comb begin
    abs_a_d = (in_signed && in_a[W-1]) ? (~in_a + ONE_W) : in_a;
    abs_b_d = (in_signed && in_b[W-1]) ? (~in_b + ONE_W) : in_b;
    neg_d   = in_signed && (in_a[W-1] ^ in_b[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      ma1_q  <= '0;
      mb1_q  <= '0;
      neg1_q <= 1'b0;
      tag1_q <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        ma1_q  <= abs_a_d;
        mb1_q  <= abs_b_d;
        neg1_q <= neg_d;
        tag1_q <= in_tag;
      end
    end
  end

  // S2: vertical (LL, HH) and crosswise (HL, LH) half-width products.
  logic [W-1:0]     ll_d, hl_d, lh_d, hh_d;
  logic [W-1:0]     ll2_q, hl2_q, lh2_q, hh2_q;
  logic             neg2_q;
  logic [TAG_W-1:0] tag2_q;

  always_comb begin
    ll_d = {{H{1'b0}}, ma1_q[H-1:0]} * {{H{1'b0}}, mb1_q[H-1:0]};
    hl_d = {{H{1'b0}}, ma1_q[W-1:H]} * {{H{1'b0}}, mb1_q[H-1:0]};
    lh_d = {{H{1'b0}}, ma1_q[H-1:0]} * {{H{1'b0}}, mb1_q[W-1:H]};
    hh_d = {{H{1'b0}}, ma1_q[W-1:H]} * {{H{1'b0}}, mb1_q[W-1:H]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      ll2_q  <= '0;
      hl2_q  <= '0;
      lh2_q  <= '0;
      hh2_q  <= '0;
      neg2_q <= 1'b0;
      tag2_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        ll2_q  <= ll_d;
        hl2_q  <= hl_d;
        lh2_q  <= lh_d;
        hh2_q  <= hh_d;
        neg2_q <= neg1_q;
        tag2_q <= tag1_q;
      end
    end
  end

  // S3: the cross sum keeps its carry; the full magnitude always fits in 2*W bits.
  logic [W:0]       cross_d;
  logic [PW-1:0]    mag_d, p_d;
  logic [PW-1:0]    p3_q;
  logic [TAG_W-1:0] tag3_q;

  always_comb begin
    cross_d = {1'b0, hl2_q} + {1'b0, lh2_q};
    mag_d   = {hh2_q, {W{1'b0}}}
            + {{(H-1){1'b0}}, cross_d, {H{1'b0}}}
            + {{W{1'b0}}, ll2_q};
    p_d     = neg2_q ? (~mag_d + ONE_P) : mag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      p3_q   <= '0;
      tag3_q <= '0;
    end else if (en3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        p3_q   <= p_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_p     = p3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_mul_vedic_pipe.sv
// Bench for mul_vedic_pipe (W=8, TAG_W=4): directed and random beats checked against an
// arithmetic a*b model through an expected queue.
module tb_mul_vedic_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  out_tag;

  mul_vedic_pipe #(.W(8), .TAG_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [3:0]  tag_q[$];
  int          cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  bit          chk_lat = 1'b0;
  bit          hold_pend = 1'b0;
  logic [15:0] held_p;
  logic [3:0]  held_tag;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    if (s) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle; inputs set after negedge, outputs sampled 1 time unit later
  task automatic step_x(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [3:0] t, input logic ordy, input bit use_x, input logic [15:0] xp);
    logic [15:0] e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    out_ready = ordy;
    #1;
    if (hold_pend) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_p", {16'd0, out_p}, {16'd0, held_p});
      check("hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        int c;
        check("prod", {16'd0, out_p}, {16'd0, exp_q.pop_front()});
        check("tag", {28'd0, out_tag}, {28'd0, tag_q.pop_front()});
        c = cyc_q.pop_front();
        if (chk_lat) check("latency", cyc - c, 32'd3);
      end
    end
    hold_pend = out_valid && !out_ready;
    held_p    = out_p;
    held_tag  = out_tag;
    if (v && in_ready) begin
      e = use_x ? xp : model(a, b, s);
      exp_q.push_back(e);
      tag_q.push_back(t);
      cyc_q.push_back(cyc);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic ordy);
    step_x(v, a, b, s, t, ordy, 1'b0, 16'h0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
      k++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_p", {16'd0, out_p}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // directed unsigned and signed products, with exact expected constants
    chk_lat = 1'b1;
    step_x(1'b1, 8'd255, 8'd255, 1'b0, 4'd5, 1'b1, 1'b1, 16'hFE01);
    step_x(1'b1, 8'd15,  8'd16,  1'b0, 4'd1, 1'b1, 1'b1, 16'd240);
    step_x(1'b1, 8'h80,  8'h80,  1'b1, 4'd2, 1'b1, 1'b1, 16'h4000);
    step_x(1'b1, 8'hFF,  8'd127, 1'b1, 4'd3, 1'b1, 1'b1, 16'hFF81);
    step_x(1'b1, 8'h80,  8'h00,  1'b1, 4'd4, 1'b1, 1'b1, 16'h0000);
    step_x(1'b1, 8'h00,  8'hFF,  1'b1, 4'd6, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 6; i++)
      step_x(1'b1, 8'h80, 8'h80, 1'(i % 2), 4'(i), 1'b1, 1'b1, 16'h4000);
    drain(10);

    // streaming: 100 back-to-back random beats at full rate
    acc0 = n_acc;
    for (int i = 0; i < 100; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b1);
    check("stream_accepted", n_acc - acc0, 32'd100);
    drain(10);
    chk_lat = 1'b0;

    // backpressure: sink stalled for 6 cycles
    acc0 = n_acc;
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    check("bp_accepted", n_acc - acc0, 32'd3);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    drain(10);

    // asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_p", {16'd0, out_p}, 32'd0);
    check("arst_out_tag", {28'd0, out_tag}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    cyc_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
      check("no_stale", {31'd0, out_valid}, 32'd0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // random valid/ready, both modes, 10k accepted beats
    acc0 = n_acc;
    while (n_acc - acc0 < 10000 && cyc < 90000)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom),
           4'($urandom), 1'($urandom_range(0, 1)));
    check("rand_accepted", n_acc - acc0, 32'd10000);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
